// File: rtl/result_sequencer_if.sv
// Bundles the channel inputs, the DIRECT/SCAN controls and the streaming
// output handshake for result_sequencer. The master side drives the inputs.
interface result_sequencer_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int SEL_WIDTH    = 2
);
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_data;
    logic [SEL_WIDTH-1:0]               sel;
    logic                               mode;
    logic                               start;
    logic                               out_ready;
    logic [DATA_WIDTH-1:0]              data_out;
    logic [SEL_WIDTH-1:0]               out_sel;
    logic                               out_valid;
    logic                               out_last;
    logic                               busy;
    logic                               done;

    modport master (
        output ch_data, sel, mode, start, out_ready,
        input  data_out, out_sel, out_valid, out_last, busy, done
    );

    modport slave (
        input  ch_data, sel, mode, start, out_ready,
        output data_out, out_sel, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/result_sequencer.sv
// Result output selector: a registered channel mux in DIRECT mode, or a
// snapshot-and-stream engine with valid/ready handshaking in SCAN mode.
module result_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int SEL_WIDTH    = 2,
    parameter int SCAN_DESCEND = 0
) (
    input  logic                clk,
    input  logic                reset,
    result_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [SEL_WIDTH-1:0] TOP_CH   = SEL_WIDTH'(NUM_CHANNELS - 1);
    localparam logic [SEL_WIDTH-1:0] FIRST_CH = (SCAN_DESCEND != 0) ? TOP_CH : '0;
    localparam logic [SEL_WIDTH-1:0] LAST_CH  = (SCAN_DESCEND != 0) ? '0 : TOP_CH;

    state_t                             state_q, state_d;
    logic [DATA_WIDTH-1:0]              data_q, data_d;
    logic [SEL_WIDTH-1:0]               sel_q, sel_d;
    logic                               valid_q, valid_d;
    logic                               last_q, last_d;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] snap_q, snap_d;

    logic                               transfer;
    logic [SEL_WIDTH-1:0]               next_ch;
    logic                               busy;
    logic                               done;

    // Out-of-range indices fall through the loop and yield zero.
    function automatic logic [DATA_WIDTH-1:0] pick(
        input logic [NUM_CHANNELS*DATA_WIDTH-1:0] vec,
        input logic [SEL_WIDTH-1:0]               idx
    );
        logic [DATA_WIDTH-1:0] word;
        word = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            if (idx == SEL_WIDTH'(i)) begin
                word = vec[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        return word;
    endfunction

    assign transfer = valid_q & bus.out_ready;
    assign next_ch  = (SCAN_DESCEND != 0) ? sel_q - SEL_WIDTH'(1) : sel_q + SEL_WIDTH'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            snap_q  <= snap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.mode && bus.start) state_d = S_SCAN;
            S_SCAN:  if (transfer && last_q)    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        last_d  = last_q;
        snap_d  = snap_q;
        case (state_q)
            S_IDLE: begin
                if (!bus.mode) begin
                    data_d  = pick(bus.ch_data, bus.sel);
                    sel_d   = bus.sel;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end else if (bus.start) begin
                    // First beat comes straight from the live inputs, identical to the snapshot.
                    snap_d  = bus.ch_data;
                    data_d  = pick(bus.ch_data, FIRST_CH);
                    sel_d   = FIRST_CH;
                    valid_d = 1'b1;
                    last_d  = (FIRST_CH == LAST_CH);
                end
            end
            S_SCAN: begin
                if (transfer) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        data_d = pick(snap_q, next_ch);
                        sel_d  = next_ch;
                        last_d = (next_ch == LAST_CH);
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    assign bus.data_out  = data_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;
    assign bus.busy      = busy;
    assign bus.done      = done;
endmodule

// File: tb/tb_result_sequencer.sv
// Directed bench for result_sequencer: a 4-channel ascending instance and an
// 8-channel descending instance, checked with immediate assertions.
module tb_result_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    result_sequencer_if #(.DATA_WIDTH(8), .NUM_CHANNELS(4), .SEL_WIDTH(2)) bus_a ();
    result_sequencer_if #(.DATA_WIDTH(8), .NUM_CHANNELS(8), .SEL_WIDTH(3)) bus_b ();

    result_sequencer #(
        .DATA_WIDTH(8), .NUM_CHANNELS(4), .SEL_WIDTH(2), .SCAN_DESCEND(0)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    result_sequencer #(
        .DATA_WIDTH(8), .NUM_CHANNELS(8), .SEL_WIDTH(3), .SCAN_DESCEND(1)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks data/sel/valid/last/busy/done of instance A in one call.
    task automatic check_a(input string tag, input logic [7:0] d, input logic [1:0] s,
                           input logic v, input logic l, input logic b, input logic dn);
        check({tag, ".data"},  64'(bus_a.data_out),  64'(d));
        check({tag, ".sel"},   64'(bus_a.out_sel),   64'(s));
        check({tag, ".valid"}, 64'(bus_a.out_valid), 64'(v));
        check({tag, ".last"},  64'(bus_a.out_last),  64'(l));
        check({tag, ".busy"},  64'(bus_a.busy),      64'(b));
        check({tag, ".done"},  64'(bus_a.done),      64'(dn));
    endtask

    initial begin
        reset = 1'b1;
        bus_a.ch_data = '0; bus_a.sel = '0; bus_a.mode = 1'b0;
        bus_a.start = 1'b0; bus_a.out_ready = 1'b0;
        bus_b.ch_data = '0; bus_b.sel = '0; bus_b.mode = 1'b0;
        bus_b.start = 1'b0; bus_b.out_ready = 1'b0;

        tick();
        check_a("rst", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // DIRECT
        bus_a.ch_data = 32'h01332211;
        bus_a.sel = 2'd2;
        tick();
        check_a("dir_sel2", 8'h33, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        bus_a.sel = 2'd0; tick(); check_a("dir_s0", 8'h11, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus_a.sel = 2'd1; tick(); check_a("dir_s1", 8'h22, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        bus_a.sel = 2'd2; tick(); check_a("dir_s2", 8'h33, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        bus_a.sel = 2'd3; tick(); check_a("dir_s3", 8'h01, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // SCAN, always ready
        bus_a.mode = 1'b1; bus_a.start = 1'b1; bus_a.out_ready = 1'b1;
        tick(); bus_a.start = 1'b0;
        check_a("scan_b0", 8'h11, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(); check_a("scan_b1", 8'h22, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(); check_a("scan_b2", 8'h33, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(); check_a("scan_b3", 8'h01, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(); check_a("scan_done", 8'h01, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(); check_a("scan_idle", 8'h01, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); check_a("idle_hold", 8'h01, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Backpressure on the second beat
        bus_a.out_ready = 1'b0; bus_a.start = 1'b1;
        tick(); bus_a.start = 1'b0;
        check_a("bp_b0", 8'h11, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(); check_a("bp_b0_hold", 8'h11, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        bus_a.out_ready = 1'b1;
        tick(); check_a("bp_b1", 8'h22, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        bus_a.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); check_a("bp_stall", 8'h22, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        bus_a.out_ready = 1'b1;
        tick(); check_a("bp_b2", 8'h33, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(); check_a("bp_b3", 8'h01, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(); check_a("bp_done", 8'h01, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(); check_a("bp_idle", 8'h01, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Snapshot immunity and start ignored while busy
        bus_a.start = 1'b1;
        tick();
        check_a("snap_b0", 8'h11, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        bus_a.ch_data = 32'hAABBCCFF;
        tick(); bus_a.start = 1'b0;
        check_a("snap_b1", 8'h22, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(); check_a("snap_b2", 8'h33, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(); check_a("snap_b3", 8'h01, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(); check_a("snap_done", 8'h01, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(); check_a("snap_idle", 8'h01, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); check_a("snap_norescan", 8'h01, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-scan
        bus_a.ch_data = 32'h01332211; bus_a.start = 1'b1; bus_a.out_ready = 1'b0;
        tick(); bus_a.start = 1'b0;
        check_a("ar_b0", 8'h11, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1 check_a("ar_async", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus_a.out_ready = 1'b1;
        tick(); check_a("ar_held", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick(); check_a("ar_after", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); check_a("ar_nodone", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Descending 8-channel instance
        bus_b.ch_data = 64'h7060504030201000;
        bus_b.mode = 1'b1; bus_b.start = 1'b1; bus_b.out_ready = 1'b1;
        tick(); bus_b.start = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            check("desc.data",  64'(bus_b.data_out),  64'(i * 16));
            check("desc.sel",   64'(bus_b.out_sel),   64'(i));
            check("desc.valid", 64'(bus_b.out_valid), 64'd1);
            check("desc.last",  64'(bus_b.out_last),  64'(i == 0));
            tick();
        end
        check("desc_done.done",  64'(bus_b.done),      64'd1);
        check("desc_done.valid", 64'(bus_b.out_valid), 64'd0);
        check("desc_done.busy",  64'(bus_b.busy),      64'd1);
        tick();
        check("desc_idle.done", 64'(bus_b.done), 64'd0);
        check("desc_idle.busy", 64'(bus_b.busy), 64'd0);
        bus_b.mode = 1'b0; bus_b.sel = 3'd5;
        tick();
        check("desc_dir.data",  64'(bus_b.data_out),  64'h50);
        check("desc_dir.sel",   64'(bus_b.out_sel),   64'd5);
        check("desc_dir.valid", 64'(bus_b.out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
